// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core port, the external loader port and the shared memory.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_ack;
  logic          core_err;
  logic [DW-1:0] core_rdata;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_ack;
  logic          ext_err;
  logic [DW-1:0] ext_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_ack, core_err, core_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_err, ext_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_ack, core_err, core_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_err, ext_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single ready-handshake memory, with a transfer watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the core has fixed priority.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          owner_r, owner_s;
  logic          last_r, last_s;
  logic          mem_req_r, mem_req_s;
  logic          mem_we_r, mem_we_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_s;
  logic          core_ack_r, core_ack_s, core_err_r, core_err_s;
  logic [DW-1:0] core_rdata_r, core_rdata_s;
  logic          ext_ack_r, ext_ack_s, ext_err_r, ext_err_s;
  logic [DW-1:0] ext_rdata_r, ext_rdata_s;
  logic          grant_ext_s;
  logic          done_s;
  logic          resp_err_s;
  logic [DW-1:0] resp_rdata_s;

  // Arbitration decision between the two requesters for an IDLE grant.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    grant_ext_s = bus.ext_req & (~bus.core_req | ~last_r);
`else
    grant_ext_s = bus.ext_req & ~bus.core_req;
`endif
  end

  // Next-state and next-output logic for the IDLE/BUSY/RESP sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    owner_s      = owner_r;
    last_s       = last_r;
    mem_req_s    = mem_req_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    core_ack_s   = 1'b0;
    core_err_s   = core_err_r;
    core_rdata_s = core_rdata_r;
    ext_ack_s    = 1'b0;
    ext_err_s    = ext_err_r;
    ext_rdata_s  = ext_rdata_r;
    done_s       = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = {DW{1'b0}};

    case (state_r)
      IDLE: begin
        if (bus.core_req | bus.ext_req) begin
          owner_s     = grant_ext_s;
          last_s      = grant_ext_s;
          mem_we_s    = grant_ext_s ? bus.ext_we    : bus.core_we;
          mem_addr_s  = grant_ext_s ? bus.ext_addr  : bus.core_addr;
          mem_wdata_s = grant_ext_s ? bus.ext_wdata : bus.core_wdata;
          cnt_s       = {CW{1'b0}};
          mem_req_s   = 1'b1;
          state_s     = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // The counter stops at its last value; reaching it ends the transfer.
        if (cnt_r != CNT_LAST) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
        if (bus.mem_ready) begin
          done_s       = 1'b1;
          resp_err_s   = 1'b0;
          resp_rdata_s = mem_we_r ? {DW{1'b0}} : bus.mem_rdata;
        end else if (cnt_r == CNT_LAST) begin
          done_s       = 1'b1;
          resp_err_s   = 1'b1;
          resp_rdata_s = {DW{1'b0}};
        end else begin
          done_s = 1'b0;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase

    if (done_s) begin
      mem_req_s = 1'b0;
      state_s   = RESP;
      if (owner_r) begin
        ext_ack_s   = 1'b1;
        ext_err_s   = resp_err_s;
        ext_rdata_s = resp_rdata_s;
      end else begin
        core_ack_s   = 1'b1;
        core_err_s   = resp_err_s;
        core_rdata_s = resp_rdata_s;
      end
    end else begin
      mem_req_s = mem_req_s;
    end
  end

  // Registered state, memory request fields and response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      owner_r      <= 1'b0;
      last_r       <= 1'b1;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {AW{1'b0}};
      mem_wdata_r  <= {DW{1'b0}};
      core_ack_r   <= 1'b0;
      core_err_r   <= 1'b0;
      core_rdata_r <= {DW{1'b0}};
      ext_ack_r    <= 1'b0;
      ext_err_r    <= 1'b0;
      ext_rdata_r  <= {DW{1'b0}};
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      owner_r      <= owner_s;
      last_r       <= last_s;
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      core_ack_r   <= core_ack_s;
      core_err_r   <= core_err_s;
      core_rdata_r <= core_rdata_s;
      ext_ack_r    <= ext_ack_s;
      ext_err_r    <= ext_err_s;
      ext_rdata_r  <= ext_rdata_s;
    end
  end

  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.core_ack   = core_ack_r;
  assign bus.core_err   = core_err_r;
  assign bus.core_rdata = core_rdata_r;
  assign bus.ext_ack    = ext_ack_r;
  assign bus.ext_err    = ext_err_r;
  assign bus.ext_rdata  = ext_rdata_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset/contention sequences,
// and randomized two-port traffic predicted by a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int          next_k;
  bit          in_burst;
  int          bcnt;
  logic        seen_we;
  logic [31:0] seen_addr, seen_wdata;
  bit          unstable;

  bit          pend [2];
  logic        p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  int          model_last;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive_ports();
    bus.core_req   = pend[0];
    bus.core_we    = p_we[0];
    bus.core_addr  = p_addr[0];
    bus.core_wdata = p_wdata[0];
    bus.ext_req    = pend[1];
    bus.ext_we     = p_we[1];
    bus.ext_addr   = p_addr[1];
    bus.ext_wdata  = p_wdata[1];
  endtask

  // Variable-latency memory: ready after next_k cycles of mem_req, garbage data otherwise.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    in_burst = 1'b0;
    bcnt = 0;
    unstable = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (!in_burst) begin
          in_burst   = 1'b1;
          bcnt       = 0;
          seen_we    = bus.mem_we;
          seen_addr  = bus.mem_addr;
          seen_wdata = bus.mem_wdata;
          unstable   = 1'b0;
        end else if (bus.mem_we !== seen_we || bus.mem_addr !== seen_addr ||
                     bus.mem_wdata !== seen_wdata) begin
          unstable = 1'b1;
        end
        if (bcnt == next_k) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we) begin
            bus.mem_rdata = $urandom;
            dev_mem[bus.mem_addr] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = dev_read(bus.mem_addr);
          end
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
        bcnt++;
      end else begin
        in_burst = 1'b0;
        bus.mem_ready = 1'b0;
      end
    end
  end

  // One transfer from an IDLE cycle: predict with the model, run it, check, release winner.
  task automatic step(input int k, output int got, output int lat,
                      output logic [31:0] rd, output logic er);
    int          exp_port;
    bit          exp_to;
    int          exp_lat;
    logic [31:0] exp_rd;
    int          req_lat;
    if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_RR_EN
      exp_port = (model_last == 0) ? 1 : 0;
`else
      exp_port = 0;
`endif
    end else begin
      exp_port = pend[1] ? 1 : 0;
    end
    exp_to  = (k < 0) || (k > TIMEOUT - 1);
    exp_lat = exp_to ? TIMEOUT + 1 : k + 2;
    exp_rd  = (exp_to || p_we[exp_port]) ? 32'h0 : ref_read(p_addr[exp_port]);

    next_k = k;
    drive_ports();
    got = -1; lat = 0; rd = 32'h0; er = 1'b0; req_lat = 0;
    for (int c = 1; c <= TIMEOUT + 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_req === 1'b1 && req_lat == 0) req_lat = c;
      if (bus.core_ack === 1'b1 || bus.ext_ack === 1'b1) begin
        if (bus.core_ack === 1'b1 && bus.ext_ack === 1'b1) got = 2;
        else got = (bus.ext_ack === 1'b1) ? 1 : 0;
        lat = c;
        rd  = (got == 1) ? bus.ext_rdata : bus.core_rdata;
        er  = (got == 1) ? bus.ext_err : bus.core_err;
        break;
      end
    end
    chk("grant_port", got, exp_port);
    chk("ack_latency", lat, exp_lat);
    chk("ack_rdata", rd, exp_rd);
    chk("ack_err", {31'h0, er}, {31'h0, exp_to});
    chk("mem_req_latency", req_lat, 1);
    chk("mem_we", {31'h0, seen_we}, {31'h0, p_we[exp_port]});
    chk("mem_addr", seen_addr, p_addr[exp_port]);
    chk("mem_wdata", seen_wdata, p_wdata[exp_port]);
    chk("mem_stable", {31'h0, unstable}, 32'h0);

    model_last = exp_port;
    if (p_we[exp_port] && !exp_to) ref_mem[p_addr[exp_port]] = p_wdata[exp_port];

    pend[exp_port] = 1'b0;
    drive_ports();
    @(posedge clk);
    @(negedge clk);
    chk("ack_pulse", {30'h0, bus.ext_ack, bus.core_ack}, 32'h0);
  endtask

  initial begin
    int          got, lat, acks;
    logic [31:0] rd;
    logic        er;
    int          exp_order [4];
    int          r, k;

    tbl[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,          0,  2, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1, 1'b1, 32'h0000_0040, 32'h1234_5678,  3,  5, 32'h0,         1'b0};
    tbl[2] = '{0, 1'b0, 32'h0000_0040, 32'h0,          1,  3, 32'h1234_5678, 1'b0};
    tbl[3] = '{1, 1'b0, 32'h0000_0100, 32'h0,          2,  4, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{0, 1'b0, 32'h0000_0100, 32'h0,         -1, 17, 32'h0,         1'b1};
    tbl[5] = '{0, 1'b0, 32'h0000_0040, 32'h0,         15, 17, 32'h1234_5678, 1'b0};
    tbl[6] = '{1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, -1, 17, 32'h0,         1'b1};
    tbl[7] = '{0, 1'b0, 32'h0000_0080, 32'h0,          0,  2, 32'h0080_FF7F, 1'b0};
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    reset = 1'b0;
    next_k = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 32'h0; p_wdata[p] = 32'h0;
    end
    drive_ports();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_acks_errs", {28'h0, bus.core_ack, bus.ext_ack, bus.core_err, bus.ext_err}, 32'h0);
    chk("rst_core_rdata", bus.core_rdata, 32'h0);
    chk("rst_ext_rdata", bus.ext_rdata, 32'h0);
    reset = 1'b1;
    model_last = 1;
    @(negedge clk);

    // Directed vectors, one port at a time.
    for (int i = 0; i < 8; i++) begin
      pend[tbl[i].port]    = 1'b1;
      p_we[tbl[i].port]    = tbl[i].we;
      p_addr[tbl[i].port]  = tbl[i].addr;
      p_wdata[tbl[i].port] = tbl[i].wdata;
      step(tbl[i].k, got, lat, rd, er);
      chk("vec_port", got, tbl[i].port);
      chk("vec_latency", lat, tbl[i].exp_lat);
      chk("vec_rdata", rd, tbl[i].exp_rdata);
      chk("vec_err", {31'h0, er}, {31'h0, tbl[i].exp_err});
    end

    // Reset in the second BUSY cycle of a k=5 read abandons the transfer.
    next_k = 5;
    pend[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 32'h0000_0100; p_wdata[0] = 32'h0;
    drive_ports();
    @(posedge clk); @(negedge clk);
    chk("abandon_busy", {31'h0, bus.mem_req}, 32'h1);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abandon_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("abandon_mem_addr", bus.mem_addr, 32'h0);
    reset = 1'b1;
    pend[0] = 1'b0;
    drive_ports();
    model_last = 1;
    acks = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (bus.core_ack === 1'b1 || bus.ext_ack === 1'b1) acks++;
    end
    chk("abandon_no_ack", acks, 0);

    // Both ports hold requests for four transfers.
    pend[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 32'h0000_0200; p_wdata[0] = 32'h0;
    pend[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 32'h0000_0300; p_wdata[1] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step(0, got, lat, rd, er);
      chk("contest_order", got, exp_order[i]);
      if (got == 0 || got == 1) pend[got] = 1'b1;
    end

    // Randomized two-port traffic.
    for (int n = 0; n < 150; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]    = 1'b1;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = 32'h0000_0200 + 32'($urandom_range(0, 7) * 4);
          p_wdata[p] = $urandom;
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 32'h0000_0204; p_wdata[0] = 32'h0;
      end
      r = $urandom_range(0, 9);
      if (r <= 5) k = r;
      else if (r == 6) k = -1;
      else if (r == 7) k = TIMEOUT - 1;
      else if (r == 8) k = TIMEOUT;
      else k = $urandom_range(6, 14);
      step(k, got, lat, rd, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified instruction/data memory of the multicycle RV32 core between the core (fetch, load, store) and an external loader/DMA port. Requests are accepted one at a time and forwarded to a variable-latency memory with a ready handshake. Each accepted request gets one ack pulse carrying read data. A watchdog counter terminates transfers the memory never completes.

## Interface
- `AW`, 32, address width in bits.
- `DW`, 32, data width in bits; word accesses only.
- `TIMEOUT`, 16, maximum cycles a transfer may spend in BUSY; legal range ≥2.
- `clk` in 1 — rising-edge clock.
- `reset` in 1 — one clock; reset is synchronous and active-low.
- `core_req`, `core_we` in 1 — core request, write enable.
- `core_addr` in AW, `core_wdata` in DW — core address, write data.
- `core_ack` out 1 — one-cycle completion pulse to the core.
- `core_err` out 1 — completion was a timeout; valid with `core_ack`.
- `core_rdata` out DW — read data; valid with `core_ack`.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_ack`, `ext_err`, `ext_rdata` — same as the core port, for the external requester.
- `mem_req` out 1 — memory request; held until `mem_ready`.
- `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out DW — registered, stable while `mem_req`=1.
- `mem_rdata` in DW — memory read data; valid when `mem_ready`=1.
- `mem_ready` in 1 — memory completion. It is sampled only while `mem_req`=1.

## Operation
- States: IDLE, BUSY, RESP. Registered `owner` bit: 0=core, 1=ext. Registered `last` bit: owner of the previous grant.
- IDLE: no request pending → stay in IDLE. Otherwise grant one requester (see Configuration):
  - latch the winner's we/addr/wdata into the `mem_*` registers;
  - set `owner`, set `last`=`owner`;
  - clear the timeout counter;
  - go to BUSY.
- BUSY: `mem_req`=1 and the counter increments each cycle.
  - `mem_ready`=1 → capture `mem_rdata` (0 for writes), err=0, go to RESP.
  - Otherwise, counter = TIMEOUT-1 → rdata=0, err=1, go to RESP.
  - `mem_ready` and timeout in the same cycle → `mem_ready` wins, err=0.
- RESP: the owner's ack=1 with the registered rdata/err; the other port's ack=0. Go to IDLE. Requests are ignored in RESP.
- Requester rules:
  - hold req/we/addr/wdata stable from assertion until its ack;
  - deassert req, or present the next request, in the cycle after ack;
  - deasserting req before ack is illegal; the arbiter completes the transfer regardless.
- The counter is $clog2(TIMEOUT) bits wide and saturates; it never wraps while in BUSY.

## Timing
- Reset (`reset`=0 at a clock edge):
  - state=IDLE;
  - `mem_req`, `mem_we`, both acks, both errs = 0;
  - `mem_addr`, `mem_wdata`, both rdatas = 0;
  - counter = 0, `owner`=0, `last`=1, so the core wins the first contested grant.
- Reset mid-transfer abandons it: `mem_req` drops the next cycle and no ack is issued. The memory must tolerate an abandoned request.
- Latency:
  - request seen in IDLE at cycle N → `mem_req` high at N+1;
  - `mem_ready` at N+1+k → ack at N+2+k;
  - minimum request-to-ack is 2 cycles; back-to-back transfers start every 3+k cycles.
- Timeout: with no `mem_ready`, ack with err=1 arrives at N+1+TIMEOUT.
- All outputs are registered; none depends combinationally on an input.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. When both requests are pending in IDLE, the grant goes to the port that is not `last`.
- Undefined: fixed priority. The core always wins a contest. `last` is still maintained but ignored. The external port can starve while the core issues back-to-back requests; this is acceptable for boot-time loading with the core held.

## Test plan
- Single core read, addr 0x100, memory returns 0xDEADBEEF with k=0 → `mem_req` at cycle 1, `core_ack`=1 with rdata=0xDEADBEEF and err=0 at cycle 2.
- Ext write, addr 0x40, wdata 0x12345678, k=3 → `mem_we`=1 and `mem_addr`/`mem_wdata` stable for 4 cycles; `ext_ack` 1 cycle after `mem_ready`; `ext_rdata`=0.
- Both ports hold req for 4 transfers:
  - RR_EN defined → grants core, ext, core, ext;
  - RR_EN undefined → 4 core grants, no `ext_ack`.
- TIMEOUT=16, `mem_ready` never asserted → `core_ack`=1 with err=1 and rdata=0 at cycle 17. A further `mem_ready` at timeout-1 returns err=0.
- `reset`=0 in the second BUSY cycle of a k=5 read → `mem_req`=0 the next cycle, no ack. After release, a contested request grants the core first.
